decoder_grant_arbiter: RTL and testbench

//   4-way round-robin arbiter for a shared resource selected by the 2x4 decoder.

---
 rtl/decoder_grant_arbiter_pkg.sv | 13 +
 rtl/decoder_grant_arbiter_decoder2x4.sv | 13 +
 rtl/decoder_grant_arbiter.sv | 98 +++++++++
 tb/tb_decoder_grant_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_grant_arbiter_pkg.sv
// Shared definitions for the decoder-driven round-robin grant arbiter.
package dec_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_grant_arbiter_decoder2x4.sv
// 2-to-4 binary-to-one-hot decoder.
module decoder2x4 (
  input  logic [1:0] a,
  output logic [3:0] y
);

  // One-hot expansion of the binary select.
  always_comb begin
    y    = '0;
    y[a] = 1'b1;
  end

endmodule

// File: rtl/decoder_grant_arbiter.sv
// 4-way round-robin arbiter with hold limit; one-hot grant via decoder2x4.
module decoder_grant_arbiter
  import dec_arb_pkg::*;
#(
  parameter  int unsigned MAX_HOLD = 8,
  localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [3:0]       done,
  output logic [3:0]       gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             busy,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             rel_early;
  logic             hold_hit;
  logic [3:0]       dec_y;

  // First requester found scanning p, p+1, ... (mod 4); the reverse loop
  // lets the smallest offset win as the last assignment.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [3:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] cand;
    rr_pick = p;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      cand = p + IDX_W'(i - 1);
      if (r[cand]) rr_pick = cand;
    end
  endfunction

  // Next-state logic: arbitration in IDLE, hold/release in GRANT, one dead GAP cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    rel_early = done[idx_q] | ~req[idx_q];
    hold_hit  = (cnt_q == CNT_W'(MAX_HOLD - 1));
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          idx_d   = rr_pick(req, ptr_q);
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (cnt_q != CNT_W'(MAX_HOLD)) cnt_d = cnt_q + CNT_W'(1);
        if (rel_early || hold_hit) begin
          ptr_d     = idx_q + IDX_W'(1);
          state_d   = ST_GAP;
          timeout_d = ~rel_early;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  decoder2x4 u_dec (
    .a (idx_q),
    .y (dec_y)
  );

  assign gnt_valid = (state_q == ST_GRANT);
  assign busy      = (state_q != ST_IDLE);
  assign timeout   = timeout_q;
  assign gnt_idx   = idx_q;
  assign gnt       = dec_y & {NUM_REQ{gnt_valid}};

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Scoreboard bench for decoder_grant_arbiter: reference model pushes expected
// outputs each cycle, monitor pops and compares on the opposite clock edge.
module tb_decoder_grant_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;
  logic       timeout;

  typedef struct {
    logic [3:0] gnt;
    logic       valid;
    logic       busy;
    logic       to;
    logic [1:0] idx;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // reference model state
  int   m_owner;
  int   m_held;
  int   m_ptr;
  bit   m_gap;
  bit   m_to;

  decoder_grant_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: one grant owner at a time, counted hold, single gap cycle.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_gap = 0; m_to = 0;
      sbq.delete();
    end else begin
      if (m_owner >= 0) begin
        m_held++;
        if (done[m_owner] || !req[m_owner] || m_held == MAX_HOLD) begin
          m_to    = !(done[m_owner] || !req[m_owner]);
          m_ptr   = (m_owner + 1) % 4;
          e.idx   = 2'(m_owner);
          m_owner = -1;
          m_gap   = 1;
        end
      end else if (m_gap) begin
        m_gap = 0;
        m_to  = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (req[(m_ptr + i) % 4]) begin
            m_owner = (m_ptr + i) % 4;
            m_held  = 0;
            break;
          end
        end
      end
      e.valid = (m_owner >= 0);
      e.gnt   = e.valid ? 4'(1 << m_owner) : 4'b0000;
      e.idx   = e.valid ? 2'(m_owner) : 2'd0;
      e.busy  = e.valid || m_gap;
      e.to    = m_gap && m_to;
      sbq.push_back(e);
    end
  end

  task automatic compare(input string name, input exp_t e, input bit chk_idx);
    tests++;
    if (gnt !== e.gnt || gnt_valid !== e.valid || busy !== e.busy ||
        timeout !== e.to || (chk_idx && gnt_idx !== e.idx)) begin
      fails++;
      $display("FAIL %s @%0t: got gnt=%b valid=%b busy=%b timeout=%b idx=%0d, want gnt=%b valid=%b busy=%b timeout=%b idx=%0d",
               name, $time, gnt, gnt_valid, busy, timeout, gnt_idx,
               e.gnt, e.valid, e.busy, e.to, e.idx);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest expected record.
  always @(negedge clk) begin
    exp_t z;
    z.gnt = 4'b0000; z.valid = 0; z.busy = 0; z.to = 0; z.idx = 2'd0;
    if (!rst_n) compare("reset", z, 1'b1);
    else if (sbq.size() == 0) compare("post_reset_idle", z, 1'b1);
    else begin
      exp_t e;
      e = sbq.pop_front();
      compare("cycle", e, e.valid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pulse done for the current grantee once it has completed h GRANT edges.
  task automatic pulse_done_at(input int h, input string name);
    for (int n = 0; n < 40; n++) begin
      tick();
      if (m_owner >= 0 && m_held == h) begin
        done = 4'(1 << m_owner);
        tick();
        done = 4'b0000;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL %s: grant with hold %0d not seen within 40 cycles, required within 40", name, h);
  endtask

  task automatic wait_owner(input int idx, input string name);
    for (int n = 0; n < 40; n++) begin
      tick();
      if (m_owner == idx) return;
    end
    tests++; fails++;
    $display("FAIL %s: grant to %0d not seen within 40 cycles, required within 40", name, idx);
  endtask

  initial begin
    exp_t z;
    z.gnt = 4'b0000; z.valid = 0; z.busy = 0; z.to = 0; z.idx = 2'd0;
    req = 4'b0000; done = 4'b0000; rst_n = 1'b0;
    repeat (2) tick();
    req = 4'b1111;
    repeat (2) tick();
    rst_n = 1'b1;

    // rotation: each grantee releases on its 2nd GRANT cycle
    for (int g = 0; g < 5; g++) pulse_done_at(1, "rotation");

    // timeout on a lone requester, then re-grant
    req = 4'b0100;
    repeat (24) tick();

    // done coinciding with the hold limit
    pulse_done_at(MAX_HOLD - 1, "simultaneous");
    req = 4'b0000;
    repeat (3) tick();

    // spurious done and a new low-index request during a grant
    req = 4'b0010;
    wait_owner(1, "spurious_grant");
    done = 4'b1000;
    req  = 4'b0011;
    tick();
    done = 4'b0000;
    repeat (3) tick();
    req = 4'b0001;
    repeat (6) tick();
    req = 4'b0000;
    repeat (3) tick();

    // asynchronous reset in the middle of a grant
    req = 4'b1000;
    wait_owner(3, "pre_reset_grant");
    rst_n = 1'b0;
    #1;
    compare("async_reset_drop", z, 1'b1);
    tick();
    rst_n = 1'b1;
    req = 4'b1111;
    repeat (4) tick();
    req = 4'b0000;
    repeat (3) tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      req  = 4'($urandom);
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 5) == 0) req = 4'(1 << $urandom_range(0, 3));
      tick();
    end
    req = 4'b0000; done = 4'b0000;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
